// File: rtl/ps2_game_input_pkg.sv
// rtl/ps2_game_input_pkg.sv - shared scan-code constants and prefix FSM encoding
package ps2_game_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_E1     = 8'hE1;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_P      = 8'h4D;

  // Bytes that follow the E1 of the Pause sequence
  localparam logic [2:0] E1_SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_e;

  // Controller housekeeping bytes that never form a key event
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_game_input_if.sv
// rtl/ps2_game_input_if.sv - scan byte input and per-channel control outputs
interface ps2_game_input_if #(
  parameter int NUM_KEYS = 4
) ();
  logic                key_valid;
  logic [7:0]          key_data;
  logic                clear_toggles;
  logic [NUM_KEYS-1:0] key_held;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_action;
  logic                unknown_code;

  modport master (
    output key_valid, key_data, clear_toggles,
    input  key_held, key_press, key_action, unknown_code
  );

  modport slave (
    input  key_valid, key_data, clear_toggles,
    output key_held, key_press, key_action, unknown_code
  );
endinterface

// File: rtl/ps2_game_input_rate_limiter.sv
// rtl/ps2_game_input_rate_limiter.sv - auto-repeat pulse generator for one held channel
module ps2_rate_limiter #(
  parameter int PERIOD = 5_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic run_i,
  output logic pulse_o
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          pulse_q, pulse_d;

  // start wins over expiry so a coincident press yields a single pulse
  always_comb begin
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    if (start_i) begin
      cnt_d   = RELOAD;
      pulse_d = 1'b1;
    end else if (run_i) begin
      if (cnt_q == '0) begin
        cnt_d   = RELOAD;
        pulse_d = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
endmodule

// File: rtl/ps2_game_input.sv
// rtl/ps2_game_input.sv - PS/2 scan byte decoder to programmable game control channels
module ps2_game_input
  import ps2_game_pkg::*;
#(
  parameter int                      NUM_KEYS    = 4,
  parameter logic [9*NUM_KEYS-1:0]   KEY_CODES   = {9'h04D, 9'h029, 9'h174, 9'h16B},
  parameter logic [NUM_KEYS-1:0]     TOGGLE_MASK = 4'b1000,
  parameter logic [NUM_KEYS-1:0]     REPEAT_MASK = 4'b0100,
  parameter int                      FIRE_PERIOD = 5_000_000
) (
  input logic clock_i,
  input logic reset_i,
  ps2_game_input_if.slave bus
);
  state_e              state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic                make_ev, brk_ev, ext_ev;
  logic [NUM_KEYS-1:0] hit;
  logic [NUM_KEYS-1:0] held_q, held_d, press_q, press_d, toggle_q, toggle_d;
  logic [NUM_KEYS-1:0] action;
  logic                unknown_q, unknown_d;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ext_ev  = 1'b0;
    if (bus.key_valid) begin
      case (state_q)
        ST_IDLE, ST_EXT: begin
          if (bus.key_data == SC_BREAK) begin
            state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
          end else if (bus.key_data == SC_EXT) begin
            state_d = ST_EXT;
          end else if (bus.key_data == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = E1_SKIP_LEN;
          end else if (state_q == ST_IDLE && is_ignored(bus.key_data)) begin
            state_d = ST_IDLE;
          end else begin
            make_ev = 1'b1;
            ext_ev  = (state_q == ST_EXT);
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          brk_ev  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          brk_ev  = 1'b1;
          ext_ev  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Several channels may share a code; every matching channel reacts
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      hit[i] = ({ext_ev, bus.key_data} == KEY_CODES[9*i +: 9]);
    end
  end

  always_comb begin
    held_d    = held_q;
    press_d   = '0;
    toggle_d  = toggle_q;
    unknown_d = (make_ev || brk_ev) && (hit == '0);
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (make_ev && hit[i] && !held_q[i]) begin
        held_d[i]  = 1'b1;
        press_d[i] = 1'b1;
        if (TOGGLE_MASK[i]) toggle_d[i] = ~toggle_q[i];
      end else if (brk_ev && hit[i]) begin
        held_d[i] = 1'b0;
      end
    end
    if (bus.clear_toggles) toggle_d = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      skip_q    <= '0;
      held_q    <= '0;
      press_q   <= '0;
      toggle_q  <= '0;
      unknown_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      skip_q    <= skip_d;
      held_q    <= held_d;
      press_q   <= press_d;
      toggle_q  <= toggle_d;
      unknown_q <= unknown_d;
    end
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    if (TOGGLE_MASK[g]) begin : g_toggle
      assign action[g] = toggle_q[g];
    end else if (REPEAT_MASK[g]) begin : g_repeat
      ps2_rate_limiter #(.PERIOD(FIRE_PERIOD)) u_rl (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .start_i (press_d[g]),
        .run_i   (held_d[g]),
        .pulse_o (action[g])
      );
    end else begin : g_level
      assign action[g] = held_q[g];
    end
  end

  assign bus.key_held     = held_q;
  assign bus.key_press    = press_q;
  assign bus.key_action   = action;
  assign bus.unknown_code = unknown_q;
endmodule
